mpe_feeder: RTL and testbench

MPE_FEEDER -- requirements
Module: mpe_feeder

---
 rtl/mpe_feeder_if.sv | 38 +++
 rtl/mpe_feeder.sv | 130 +++++++++++++
 tb/tb_mpe_feeder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpe_feeder_if.sv
// Handshake and PE-column bus of the MPE column feeder.
// The master side drives jobs, weights and fmaps. The slave side is the feeder.
interface mpe_feeder_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUMBER_PE  = 9,
   parameter int unsigned CNT_W      = 16
);
   localparam int unsigned BUS_W = NUMBER_PE * DATA_WIDTH;

   logic                 i_start;
   logic [CNT_W-1:0]     i_num_vec;
   logic                 i_w_valid;
   logic                 o_w_ready;
   logic [BUS_W-1:0]     i_weight;
   logic                 i_fmap_valid;
   logic                 o_fmap_ready;
   logic [BUS_W-1:0]     i_fmap;
   logic                 o_weight_en;
   logic [BUS_W-1:0]     o_weight;
   logic [BUS_W-1:0]     o_fmap;
   logic [NUMBER_PE-1:0] o_left_en;
   logic [NUMBER_PE-1:0] o_right_en;
   logic                 o_psum_valid;
   logic                 o_busy;
   logic                 o_done;

   modport master (
      output i_start, i_num_vec, i_w_valid, i_weight, i_fmap_valid, i_fmap,
      input  o_w_ready, o_fmap_ready, o_weight_en, o_weight, o_fmap,
             o_left_en, o_right_en, o_psum_valid, o_busy, o_done
   );

   modport slave (
      input  i_start, i_num_vec, i_w_valid, i_weight, i_fmap_valid, i_fmap,
      output o_w_ready, o_fmap_ready, o_weight_en, o_weight, o_fmap,
             o_left_en, o_right_en, o_psum_valid, o_busy, o_done
   );
endinterface

// File: rtl/mpe_feeder.sv
// Feeds one PE column: it loads the weights once per job, streams skewed fmap beats,
// and tracks partial-sum validity out of the bottom of the column.
module mpe_feeder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUMBER_PE  = 9,
   parameter int unsigned SKEW       = 1,
   parameter int unsigned PE_LAT     = 1,
   parameter int unsigned CNT_W      = 16
) (
   input logic         i_clk,
   input logic         i_rest,
   mpe_feeder_if.slave bus
);
   localparam int unsigned LAST_ROW = (NUMBER_PE - 1) * SKEW;
   localparam int unsigned PSUM_IDX = LAST_ROW + PE_LAT;
   localparam int unsigned VLEN     = LAST_ROW + ((PE_LAT > 1) ? PE_LAT : 1) + 1;

   typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] num_vec, num_vec_nxt;
   logic             done_nxt;
   logic             w_fire;
   logic             f_fire;
   // vsr[j] is high j+1 edges after a beat was accepted
   logic [VLEN-1:0]  vsr;

   // Next-state and handshake decode
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      num_vec_nxt = num_vec;
      done_nxt    = 1'b0;
      w_fire      = 1'b0;
      f_fire      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_start) begin
               if (bus.i_num_vec == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  num_vec_nxt = bus.i_num_vec;
                  cnt_nxt     = '0;
                  state_nxt   = LOAD_W;
               end
            end
         end
         LOAD_W: begin
            if (bus.i_w_valid) begin
               w_fire    = 1'b1;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (bus.i_fmap_valid) begin
               f_fire  = 1'b1;
               cnt_nxt = cnt + CNT_W'(1);
               if ((cnt + CNT_W'(1)) == num_vec) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Every beat is already in the pipe, so the last psum is the one with nothing behind it
            if (vsr[PSUM_IDX] && (vsr[PSUM_IDX-1:0] == '0)) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, control outputs, weight register and valid pipeline
   always_ff @(posedge i_clk) begin
      if (i_rest) begin
         state            <= IDLE;
         cnt              <= '0;
         num_vec          <= '0;
         vsr              <= '0;
         bus.o_weight     <= '0;
         bus.o_weight_en  <= 1'b0;
         bus.o_done       <= 1'b0;
         bus.o_busy       <= 1'b0;
         bus.o_w_ready    <= 1'b0;
         bus.o_fmap_ready <= 1'b0;
      end else begin
         state            <= state_nxt;
         cnt              <= cnt_nxt;
         num_vec          <= num_vec_nxt;
         vsr              <= {vsr[VLEN-2:0], f_fire};
         if (w_fire) bus.o_weight <= bus.i_weight;
         bus.o_weight_en  <= w_fire;
         bus.o_done       <= done_nxt;
         bus.o_busy       <= (state_nxt != IDLE);
         bus.o_w_ready    <= (state_nxt == LOAD_W);
         bus.o_fmap_ready <= (state_nxt == STREAM);
      end
   end

   assign bus.o_psum_valid = vsr[PSUM_IDX];

   // Per-row fmap skew: row k sees its slice k*SKEW cycles after row 0
   for (genvar k = 0; k < NUMBER_PE; k++) begin : g_row
      localparam int unsigned DLY = k * SKEW;
      logic [DATA_WIDTH-1:0] row_q;

      if (DLY == 0) begin : g_direct
         always_ff @(posedge i_clk) begin
            if (i_rest)      row_q <= '0;
            else if (f_fire) row_q <= bus.i_fmap[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end else begin : g_delay
         logic [DATA_WIDTH-1:0] pipe [DLY];
         always_ff @(posedge i_clk) begin
            if (i_rest) begin
               for (int unsigned s = 0; s < DLY; s++) pipe[s] <= '0;
               row_q <= '0;
            end else begin
               pipe[0] <= bus.i_fmap[k*DATA_WIDTH +: DATA_WIDTH];
               for (int unsigned s = 1; s < DLY; s++) pipe[s] <= pipe[s-1];
               if (vsr[DLY-1]) row_q <= pipe[DLY-1];
            end
         end
      end

      assign bus.o_fmap[k*DATA_WIDTH +: DATA_WIDTH] = row_q;
      assign bus.o_left_en[k]  = vsr[DLY];
      assign bus.o_right_en[k] = vsr[DLY+1];
   end
endmodule

// File: tb/tb_mpe_feeder.sv
// Directed bench for mpe_feeder: a default build plus a SKEW=2 build on one clock.
module tb_mpe_feeder;
   localparam int unsigned DW  = 32;
   localparam int unsigned NPE = 9;
   localparam int unsigned CW  = 16;
   localparam int unsigned BW  = NPE * DW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mpe_feeder_if #(.DATA_WIDTH(DW), .NUMBER_PE(NPE), .CNT_W(CW)) bus  ();
   mpe_feeder_if #(.DATA_WIDTH(DW), .NUMBER_PE(NPE), .CNT_W(CW)) bus2 ();

   mpe_feeder #(.DATA_WIDTH(DW), .NUMBER_PE(NPE), .SKEW(1), .PE_LAT(1), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rest(rst), .bus(bus.slave));
   mpe_feeder #(.DATA_WIDTH(DW), .NUMBER_PE(NPE), .SKEW(2), .PE_LAT(1), .CNT_W(CW)) dut2 (
      .i_clk(clk), .i_rest(rst), .bus(bus2.slave));

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int base  = 0;
   int ps_cnt;
   int lcnt [NPE];
   logic [63:0] l0_map, l8_map, ps_map, dn_map, l8b_map, psb_map, dnb_map;
   logic [BW-1:0] wv, wv2, f1, f2, f3, exp_v;
   logic [31:0] fl [NPE] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

   // One clock, then sample away from the edge and log pulse positions relative to base
   task automatic step();
      int d;
      @(posedge clk);
      #1;
      cyc++;
      d = cyc - base;
      if (d >= 0 && d < 64) begin
         l0_map[d]  = bus.o_left_en[0];
         l8_map[d]  = bus.o_left_en[NPE-1];
         ps_map[d]  = bus.o_psum_valid;
         dn_map[d]  = bus.o_done;
         l8b_map[d] = bus2.o_left_en[NPE-1];
         psb_map[d] = bus2.o_psum_valid;
         dnb_map[d] = bus2.o_done;
      end
      for (int k = 0; k < NPE; k++) lcnt[k] += int'(bus.o_left_en[k]);
      ps_cnt += int'(bus.o_psum_valid);
   endtask

   task automatic clr();
      l0_map = '0; l8_map = '0; ps_map = '0; dn_map = '0;
      l8b_map = '0; psb_map = '0; dnb_map = '0;
      for (int k = 0; k < NPE; k++) lcnt[k] = 0;
      ps_cnt = 0;
      base   = cyc + 1;
   endtask

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},   BW'(bus.o_busy), BW'(0));
      chk({tag, "_wrdy"},   BW'(bus.o_w_ready), BW'(0));
      chk({tag, "_frdy"},   BW'(bus.o_fmap_ready), BW'(0));
      chk({tag, "_wen"},    BW'(bus.o_weight_en), BW'(0));
      chk({tag, "_done"},   BW'(bus.o_done), BW'(0));
      chk({tag, "_psum"},   BW'(bus.o_psum_valid), BW'(0));
      chk({tag, "_left"},   BW'(bus.o_left_en), BW'(0));
      chk({tag, "_right"},  BW'(bus.o_right_en), BW'(0));
      chk({tag, "_weight"}, bus.o_weight, BW'(0));
      chk({tag, "_fmap"},   bus.o_fmap, BW'(0));
      chk({tag, "_busy2"},  BW'(bus2.o_busy), BW'(0));
   endtask

   task automatic start_job(input logic [CW-1:0] n);
      bus.i_start = 1'b1; bus.i_num_vec = n;
      step();
      bus.i_start = 1'b0; bus.i_num_vec = '0;
   endtask

   task automatic load_w(input logic [BW-1:0] w);
      bus.i_w_valid = 1'b1; bus.i_weight = w;
      step();
      bus.i_w_valid = 1'b0; bus.i_weight = '0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !bus.o_done; i++) step();
      chk("done_seen", BW'(bus.o_done), BW'(1));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NPE; k++) begin
         wv[k*DW +: DW]  = fl[k];
         wv2[k*DW +: DW] = 32'h0000_1000 + 32'(k);
         f1[k*DW +: DW]  = 32'hA000_0000 + 32'(k * 17);
         f2[k*DW +: DW]  = 32'hB000_0000 + 32'(k);
         f3[k*DW +: DW]  = 32'hC000_0000 + 32'(k);
      end
      bus.i_start = 1'b0; bus.i_num_vec = '0; bus.i_w_valid = 1'b0; bus.i_weight = '0;
      bus.i_fmap_valid = 1'b0; bus.i_fmap = '0;
      bus2.i_start = 1'b0; bus2.i_num_vec = '0; bus2.i_w_valid = 1'b0; bus2.i_weight = '0;
      bus2.i_fmap_valid = 1'b0; bus2.i_fmap = '0;
      clr();

      // Reset state
      rst = 1'b1;
      step(); step();
      chk_zero("rst");
      rst = 1'b0;
      step();

      // N=1 job: weight strobe, per-row skew, psum and done timing
      start_job(16'd1);
      chk("j1_busy", BW'(bus.o_busy), BW'(1));
      chk("j1_wrdy", BW'(bus.o_w_ready), BW'(1));
      chk("j1_frdy", BW'(bus.o_fmap_ready), BW'(0));
      load_w(wv);
      chk("j1_wen", BW'(bus.o_weight_en), BW'(1));
      chk("j1_weight", bus.o_weight, wv);
      chk("j1_wrdy_off", BW'(bus.o_w_ready), BW'(0));
      chk("j1_frdy_on", BW'(bus.o_fmap_ready), BW'(1));
      step();
      chk("j1_wen_once", BW'(bus.o_weight_en), BW'(0));
      chk("j1_weight_hold", bus.o_weight, wv);
      clr();
      bus.i_fmap_valid = 1'b1; bus.i_fmap = f1;
      step();
      bus.i_fmap_valid = 1'b0; bus.i_fmap = ~f1;
      chk("j1_left0", BW'(bus.o_left_en), BW'(1));
      chk("j1_fmap0", BW'(bus.o_fmap[DW-1:0]), BW'(f1[DW-1:0]));
      chk("j1_frdy_drop", BW'(bus.o_fmap_ready), BW'(0));
      for (int k = 1; k < NPE; k++) begin
         step();
         chk($sformatf("j1_left%0d", k), BW'(bus.o_left_en), BW'(1) << k);
         chk($sformatf("j1_right%0d", k - 1), BW'(bus.o_right_en), BW'(1) << (k - 1));
         exp_v = BW'(f1[k*DW +: DW]);
         chk($sformatf("j1_fmap%0d", k), BW'(bus.o_fmap[k*DW +: DW]), exp_v);
      end
      step();
      chk("j1_psum", BW'(bus.o_psum_valid), BW'(1));
      chk("j1_right8", BW'(bus.o_right_en), BW'(1) << (NPE - 1));
      chk("j1_left_idle", BW'(bus.o_left_en), BW'(0));
      chk("j1_done_early", BW'(bus.o_done), BW'(0));
      step();
      chk("j1_done", BW'(bus.o_done), BW'(1));
      chk("j1_busy_off", BW'(bus.o_busy), BW'(0));
      chk("j1_fmap_hold", bus.o_fmap, f1);
      chk("j1_ps_map", BW'(ps_map), BW'(64'h1) << 9);
      step();
      chk("j1_done_once", BW'(bus.o_done), BW'(0));

      // N=4 with valid held high
      start_job(16'd4);
      load_w(wv2);
      chk("j4_weight", bus.o_weight, wv2);
      clr();
      bus.i_fmap_valid = 1'b1; bus.i_fmap = f2;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("j4_left0_b%0d", i), BW'(bus.o_left_en[0]), BW'(1));
      end
      chk("j4_frdy_drop", BW'(bus.o_fmap_ready), BW'(0));
      step(); step();
      bus.i_fmap_valid = 1'b0;
      wait_done(40);
      chk("j4_l0_map", BW'(l0_map), BW'(64'hF));
      chk("j4_ps_map", BW'(ps_map), BW'(64'hF) << 9);
      chk("j4_dn_map", BW'(dn_map), BW'(64'h1) << 13);

      // N=3 with valid pattern 1,0,1,0,1
      start_job(16'd3);
      load_w(wv);
      clr();
      bus.i_fmap = f3;
      for (int i = 0; i < 5; i++) begin
         bus.i_fmap_valid = (i % 2 == 0);
         step();
      end
      bus.i_fmap_valid = 1'b0;
      wait_done(40);
      chk("j3_l0_map", BW'(l0_map), BW'(64'h15));
      chk("j3_l8_map", BW'(l8_map), BW'(64'h15) << 8);
      chk("j3_ps_map", BW'(ps_map), BW'(64'h15) << 9);
      chk("j3_dn_map", BW'(dn_map), BW'(64'h1) << 14);
      chk("j3_ps_cnt", BW'(ps_cnt), BW'(3));
      for (int k = 0; k < NPE; k++) chk($sformatf("j3_lcnt%0d", k), BW'(lcnt[k]), BW'(3));

      // Zero-length job
      step();
      bus.i_start = 1'b1; bus.i_num_vec = '0;
      step();
      bus.i_start = 1'b0;
      chk("j0_done", BW'(bus.o_done), BW'(1));
      chk("j0_busy", BW'(bus.o_busy), BW'(0));
      chk("j0_wrdy", BW'(bus.o_w_ready), BW'(0));
      step();
      chk("j0_done_once", BW'(bus.o_done), BW'(0));
      chk("j0_busy_after", BW'(bus.o_busy), BW'(0));
      chk("j0_wrdy_after", BW'(bus.o_w_ready), BW'(0));

      // Reset two cycles after a beat of an N=2 job
      start_job(16'd2);
      load_w(wv2);
      bus.i_fmap_valid = 1'b1; bus.i_fmap = f3;
      step();
      bus.i_fmap_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk_zero("mid_rst");
      rst = 1'b0;
      clr();
      for (int i = 0; i < 15; i++) step();
      chk("mr_ps_cnt", BW'(ps_cnt), BW'(0));
      chk("mr_l8_map", BW'(l8_map), BW'(0));
      chk("mr_dn_map", BW'(dn_map), BW'(0));
      chk("mr_lcnt0", BW'(lcnt[0]), BW'(0));
      start_job(16'd1);
      load_w(wv);
      clr();
      bus.i_fmap_valid = 1'b1; bus.i_fmap = f1;
      step();
      bus.i_fmap_valid = 1'b0;
      wait_done(30);
      chk("mr_ps_map", BW'(ps_map), BW'(64'h1) << 9);
      chk("mr_dn_map2", BW'(dn_map), BW'(64'h1) << 10);
      chk("mr_weight", bus.o_weight, wv);

      // SKEW=2 build: stray start in STREAM is ignored
      bus2.i_start = 1'b1; bus2.i_num_vec = 16'd1;
      step();
      bus2.i_start = 1'b0; bus2.i_num_vec = '0;
      bus2.i_w_valid = 1'b1; bus2.i_weight = wv;
      step();
      bus2.i_w_valid = 1'b0;
      chk("s2_wen", BW'(bus2.o_weight_en), BW'(1));
      bus2.i_start = 1'b1; bus2.i_num_vec = 16'd2;
      step();
      bus2.i_start = 1'b0; bus2.i_num_vec = '0;
      chk("s2_frdy", BW'(bus2.o_fmap_ready), BW'(1));
      clr();
      bus2.i_fmap_valid = 1'b1; bus2.i_fmap = f1;
      step();
      bus2.i_fmap_valid = 1'b0;
      chk("s2_frdy_drop", BW'(bus2.o_fmap_ready), BW'(0));
      for (int i = 0; i < 40 && !bus2.o_done; i++) step();
      chk("s2_done_seen", BW'(bus2.o_done), BW'(1));
      chk("s2_l8_map", BW'(l8b_map), BW'(64'h1) << 16);
      chk("s2_ps_map", BW'(psb_map), BW'(64'h1) << 17);
      chk("s2_dn_map", BW'(dnb_map), BW'(64'h1) << 18);
      exp_v = BW'(f1[(NPE-1)*DW +: DW]);
      chk("s2_fmap8", BW'(bus2.o_fmap[(NPE-1)*DW +: DW]), exp_v);
      step();
      chk("s2_busy_off", BW'(bus2.o_busy), BW'(0));
      chk("s2_wrdy_off", BW'(bus2.o_w_ready), BW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
